pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised, elastic pipeline-stage register that replaces fixed stall/clear stage registers (e.g. fetch-to-decode) with a valid/ready handshake and a two-entry skid buffer. It carries an arbitrary-width payload, keeps full throughput under back-pressure with a fully registered upstream ready, and supports a synchronous flush that inserts bubbles. One instance sits between each pair of adjacent pipeline stages.

## Interface
- DATA_W, 64: payload width in bits (e.g. 32-bit PC+4 concatenated with 32-bit instruction).
- BUBBLE, {DATA_W{1'b0}}: payload value driven whenever the stage holds no valid entry.

- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ValidIn  in  1  upstream presents a payload.
- DataIn  in  DATA_W  upstream payload.
- ReadyOut  out  1  stage can accept; registered, no combinational path from ReadyIn.
- ValidOut  out  1  DataOut holds a valid payload.
- DataOut  out  DATA_W  head payload; equals BUBBLE when ValidOut=0.
- ReadyIn  in  1  downstream accepts this cycle.
- CLR  in  1  synchronous flush: discard all held and incoming payloads.
- Count  out  2  entries held (0, 1, 2).

## Operation
- Two storage entries: main (drives DataOut) and skid. State is EMPTY, ONE or FULL, encoded as Count 0/1/2.
- Handshakes:
  - Push when ValidIn && ReadyOut.
  - Pop when ValidOut && ReadyIn.
  - ValidIn and DataIn may change only after a push. ValidOut/DataOut are held stable until a pop or CLR.
- Outputs decode directly from registered state:
  - ReadyOut = (state != FULL)
  - ValidOut = (state != EMPTY)
- Transitions (CLR=0):
  - EMPTY: push -> ONE, main=DataIn; otherwise hold.
  - ONE:
    - push&&pop -> ONE, main=DataIn.
    - push only -> FULL, skid=DataIn.
    - pop only -> EMPTY, main=BUBBLE.
    - neither -> hold.
  - FULL: no push possible. Pop -> ONE, main=skid, skid=BUBBLE. Otherwise hold.
- CLR=1 has priority over all transitions.
  - Next state is EMPTY, with main=skid=BUBBLE.
  - ValidIn is ignored; no push occurs, even if ReadyOut=1.
  - A pop in the CLR cycle is a completed transfer; downstream owns that payload.
  - CLR held for several cycles keeps the stage EMPTY.
- Reset (RST=1, asynchronous): state EMPTY, main=skid=BUBBLE.
  - Resulting outputs: ValidOut=0, ReadyOut=1, DataOut=BUBBLE, Count=0.
  - Reset asserted mid-transfer discards everything immediately, without waiting for CLK.
- No arithmetic beyond the 2-bit state. Payload is stored verbatim and never truncated or extended.

## Timing
- Latency: push at edge N gives ValidOut=1 with that payload from edge N (visible in cycle N+1).
- Throughput: one payload per cycle while ReadyIn=1.
- ReadyOut falls in the cycle after the second entry is captured. It rises in the cycle after the pop from FULL.
  - The skid entry absorbs the one payload pushed while ReadyIn was low.
- Order is strictly FIFO: the skid entry always moves to main before any newer payload.
- After CLR at edge N: ReadyOut=1 and ValidOut=0 in cycle N+1; a push in cycle N+1 is accepted.
- RST deassertion is synchronised externally; the first push is possible on the first CLK edge after release.

## Structure
- Shared package pipe_pkg holds:
  - the state typedef (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2);
  - the default IF/ID payload width constant IFID_W=64.
- No sub-module: a single always block for state/main/skid plus continuous assigns for the outputs.
- Instantiated per pipeline boundary, e.g. IF/ID with DATA_W=64. The hazard unit drives ReadyIn low to stall and CLR to flush.

## Test plan
- Reset: assert RST mid-cycle with the stage FULL -> ValidOut=0, ReadyOut=1, Count=0, DataOut=0 immediately, without waiting for CLK.
- Streaming: push 0x1..0x8 back-to-back with ReadyIn=1 -> DataOut shows 0x1..0x8 on consecutive cycles at one-cycle latency, Count stays 1.
- Back-pressure: ReadyIn=0 while pushing 0xA, 0xB -> Count=2, ReadyOut=0, 0xC held off. Release ReadyIn -> pops 0xA, 0xB, 0xC in order, with no loss or duplication.
- Flush: FULL with 0xA, 0xB, assert CLR with ValidIn=1 and DataIn=0xC -> next cycle ValidOut=0, DataOut=0, Count=0, and 0xC never appears.
- Flush plus pop: ONE with 0x5, ReadyIn=1 and CLR=1 in the same cycle -> 0x5 is counted as delivered once, and the stage is EMPTY next cycle.
- Parameters: DATA_W=7, BUBBLE=7'h55 -> DataOut=7'h55 when empty, and the payload 7'h2A passes through unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage registers.
//   state_e : occupancy of a two-entry skid stage, encoded as its entry count
//   IFID_W  : default payload width for the IF/ID boundary ({PC+4, instruction})
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int IFID_W = 64;

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// Replaces a stall/clear stage register with a valid/ready handshake while
// keeping ReadyOut fully registered (no path from ReadyIn to ReadyOut).
//
// Ports:
//   CLK, RST           clock, asynchronous active-high reset
//   ValidIn, DataIn    upstream payload offer
//   ReadyOut           stage can accept (registered)
//   ValidOut, DataOut  head payload; DataOut = BUBBLE when not valid
//   ReadyIn            downstream accepts this cycle
//   CLR                synchronous flush, priority over all transfers
//   Count              entries held (0..2)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no entry; main = skid = BUBBLE, ReadyOut=1, ValidOut=0
// ST_ONE   | main holds head payload; skid = BUBBLE
// ST_FULL  | main holds head, skid holds the next payload; ReadyOut=0
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W = IFID_W,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ValidIn,
    input  logic [DATA_W-1:0] DataIn,
    output logic              ReadyOut,
    output logic              ValidOut,
    output logic [DATA_W-1:0] DataOut,
    input  logic              ReadyIn,
    input  logic              CLR,
    output logic [1:0]        Count
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;
    logic              push;
    logic              pop;

    // A flush cycle never accepts upstream data, even though ReadyOut may be 1.
    assign push = ValidIn && ReadyOut && !CLR;
    assign pop  = ValidOut && ReadyIn;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (CLR) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = DataIn;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = DataIn;
                    end else if (push) begin
                        state_d = ST_FULL;
                        skid_d  = DataIn;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                ST_FULL: begin
                    // ReadyOut is 0 here, so only a pop can happen; the skid
                    // entry always advances before any newer payload.
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign ReadyOut = (state_q != ST_FULL);
    assign ValidOut = (state_q != ST_EMPTY);
    assign DataOut  = main_q;
    assign Count    = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: queue-based reference model of the stage
// contents, a negedge monitor comparing every output each cycle and logging
// delivered payloads, directed scenarios, then randomized traffic.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [63:0] data_in = '0;
    logic        ready_in = 1'b0;
    logic        clr = 1'b0;
    logic        ready_out;
    logic        valid_out;
    logic [63:0] data_out;
    logic [1:0]  count;

    logic        v7 = 1'b0;
    logic [6:0]  d7 = '0;
    logic        r7 = 1'b0;
    logic        c7 = 1'b0;
    logic        ro7;
    logic        vo7;
    logic [6:0]  do7;
    logic [1:0]  cnt7;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] model_q[$];
    logic [63:0] deliv[$];
    bit          m_pop;
    bit          m_push;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .CLK(clk), .RST(rst), .ValidIn(valid_in), .DataIn(data_in),
        .ReadyOut(ready_out), .ValidOut(valid_out), .DataOut(data_out),
        .ReadyIn(ready_in), .CLR(clr), .Count(count)
    );

    pipe_stage_skid #(.DATA_W(7), .BUBBLE(7'h55)) dut7 (
        .CLK(clk), .RST(rst), .ValidIn(v7), .DataIn(d7),
        .ReadyOut(ro7), .ValidOut(vo7), .DataOut(do7),
        .ReadyIn(r7), .CLR(c7), .Count(cnt7)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the stage is a FIFO of at most two payloads.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
        end else begin
            m_pop  = (model_q.size() > 0) && ready_in;
            m_push = valid_in && (model_q.size() < 2) && !clr;
            if (clr) begin
                model_q.delete();
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (m_push) model_q.push_back(data_in);
            end
        end
    end

    always @(negedge clk) begin
        logic        ev;
        logic [63:0] ed;
        ev = (model_q.size() != 0);
        ed = ev ? model_q[0] : 64'h0;
        check("count", {62'h0, count}, 64'(model_q.size()));
        check("valid_out", {63'h0, valid_out}, {63'h0, ev});
        check("ready_out", {63'h0, ready_out}, {63'h0, (model_q.size() < 2)});
        check("data_out", data_out, ed);
        if (!rst && valid_out && ready_in) deliv.push_back(data_out);
    end

    task automatic push_one(input logic [63:0] d);
        bit acc;
        bit done;
        done = 0;
        valid_in = 1'b1;
        data_in  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            acc = ready_out && !clr;
            @(posedge clk); #2;
            if (acc) done = 1;
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL push_timeout: payload %h not accepted within 50 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic check_deliv(input string name, input logic [63:0] e[$]);
        check({name, "_len"}, 64'(deliv.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < deliv.size(); i++)
            check(name, deliv[i], e[i]);
    endtask

    initial begin
        logic [63:0] exp_l[$];
        bit acc;

        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", {63'h0, valid_out}, 64'h0);
        check("rst_ready", {63'h0, ready_out}, 64'h1);
        check("rst_count", {62'h0, count}, 64'h0);
        check("rst_data7", {57'h0, do7}, 64'h55);
        rst = 1'b0;
        @(posedge clk); #2;

        // Streaming
        deliv.delete();
        ready_in = 1'b1;
        for (int i = 1; i <= 8; i++) push_one(64'(i));
        idle(3);
        exp_l = '{64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 64'h6, 64'h7, 64'h8};
        check_deliv("stream", exp_l);

        // Back-pressure
        deliv.delete();
        ready_in = 1'b0;
        push_one(64'hA);
        push_one(64'hB);
        valid_in = 1'b1;
        data_in  = 64'hC;
        @(posedge clk); #2;
        check("bp_count", {62'h0, count}, 64'h2);
        check("bp_ready", {63'h0, ready_out}, 64'h0);
        ready_in = 1'b1;
        push_one(64'hC);
        idle(4);
        exp_l = '{64'hA, 64'hB, 64'hC};
        check_deliv("bp", exp_l);

        // Flush while full with a pending offer
        deliv.delete();
        ready_in = 1'b0;
        push_one(64'hA);
        push_one(64'hB);
        valid_in = 1'b1;
        data_in  = 64'hC;
        clr      = 1'b1;
        @(posedge clk); #2;
        clr      = 1'b0;
        valid_in = 1'b0;
        check("flush_count", {62'h0, count}, 64'h0);
        check("flush_data", data_out, 64'h0);
        check("flush_ready", {63'h0, ready_out}, 64'h1);
        ready_in = 1'b1;
        idle(3);
        exp_l = {};
        check_deliv("flush", exp_l);

        // Flush plus pop in the same cycle
        deliv.delete();
        ready_in = 1'b0;
        push_one(64'h5);
        ready_in = 1'b1;
        clr      = 1'b1;
        @(posedge clk); #2;
        clr = 1'b0;
        check("fpop_count", {62'h0, count}, 64'h0);
        idle(2);
        exp_l = '{64'h5};
        check_deliv("fpop", exp_l);

        // Asynchronous reset mid-cycle while full
        ready_in = 1'b0;
        push_one(64'h11);
        push_one(64'h22);
        idle(1);
        check("pre_rst_count", {62'h0, count}, 64'h2);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", {63'h0, valid_out}, 64'h0);
        check("arst_ready", {63'h0, ready_out}, 64'h1);
        check("arst_count", {62'h0, count}, 64'h0);
        check("arst_data", data_out, 64'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        deliv.delete();

        // Parameterised instance: 7-bit payload, non-zero bubble
        check("p7_empty", {57'h0, do7}, 64'h55);
        v7 = 1'b1;
        d7 = 7'h2A;
        @(posedge clk); #2;
        v7 = 1'b0;
        check("p7_valid", {63'h0, vo7}, 64'h1);
        check("p7_data", {57'h0, do7}, 64'h2A);
        r7 = 1'b1;
        @(posedge clk); #2;
        r7 = 1'b0;
        check("p7_valid_after", {63'h0, vo7}, 64'h0);
        check("p7_bubble", {57'h0, do7}, 64'h55);

        // Randomized traffic; payload changes only after acceptance or flush
        for (int i = 0; i < 600; i++) begin
            acc = (valid_in && ready_out) || clr;
            @(posedge clk); #2;
            if (!valid_in || acc) begin
                valid_in = ($urandom_range(3) != 0);
                data_in  = {$urandom, $urandom};
            end
            ready_in = ($urandom_range(2) != 0);
            clr      = ($urandom_range(15) == 0);
        end
        clr      = 1'b0;
        ready_in = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
